gpio_input_conditioner: RTL and testbench
=========================================

GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 65000 (1 ms at 65 MHz), giving the consecutive stable cycles needed to accept a new input level; legal range >= 2.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 26000000 (0.4 s), giving the cycles from a press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 6500000 (0.1 s), giving the cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock (clk_65 domain); all logic rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port gpio_left_in, input, 1 bit: raw, asynchronous left-button line from the peer board.
REQ-007 The block SHALL have port gpio_right_in, input, 1 bit: raw, asynchronous right-button line from the peer board.
REQ-008 The block SHALL have port left_level, output, 1 bit: debounced left state, which feeds the player-2 controller and state control.
REQ-009 The block SHALL have port right_level, output, 1 bit: debounced right state.
REQ-010 The block SHALL have port left_press, output, 1 bit: one-cycle pulse on each accepted left press or auto-repeat.
REQ-011 The block SHALL have port right_press, output, 1 bit: one-cycle pulse on each accepted right press or auto-repeat.
REQ-012 The block SHALL have port left_release, output, 1 bit: one-cycle pulse on each accepted left high-to-low transition.
REQ-013 The block SHALL have port right_release, output, 1 bit: one-cycle pulse on each accepted right high-to-low transition.

Function
REQ-014 Each input SHALL pass a two-flop synchronizer (sync1, sync2) before any other use; no other logic SHALL read the raw inputs.
REQ-015 Each channel SHALL have a debounce counter of width $clog2(DEBOUNCE_CYCLES+1) that increments on every edge where sync2 != level and clears on every edge where sync2 == level.
REQ-016 When a channel's counter reaches DEBOUNCE_CYCLES-1 and sync2 != level on the same edge, level SHALL toggle to sync2 on that edge and the counter SHALL clear.
REQ-017 Latency: if an input is first sampled high at edge 0 and held, level SHALL go high after edge DEBOUNCE_CYCLES+1; the same latency SHALL apply to low transitions.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL restart the count and SHALL NOT change level or produce any pulse.
REQ-019 The press pulse SHALL assert for exactly one cycle, registered, in the same cycle level first reads 1; the release pulse SHALL behave the same way for level first reading 0.
REQ-020 Left and right channels SHALL be fully independent; simultaneous transitions SHALL produce simultaneous pulses with no priority or masking.
REQ-021 Press and release SHALL never assert in the same cycle on one channel.

Reset
REQ-022 While rst=0, the synchronizer flops, levels, counters and all pulse outputs SHALL be 0, asynchronously.
REQ-023 After reset release, an input already high SHALL be treated as a new press: level goes high and the press pulse fires after the REQ-017 latency.
REQ-024 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse SHALL be emitted on or after release until a fresh qualification completes.

Configuration
REQ-025 With macro GPIO_AUTO_REPEAT_EN defined, each channel SHALL have a repeat counter that starts at 0 on the press pulse and counts while level=1.
REQ-026 With GPIO_AUTO_REPEAT_EN defined, press SHALL pulse again when the counter reaches REPEAT_DELAY, then every REPEAT_PERIOD cycles; the counter SHALL clear when level falls.
REQ-027 Without GPIO_AUTO_REPEAT_EN, the repeat logic SHALL be absent and press SHALL pulse only on the REQ-019 transition.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-028 A bench SHALL cover: gpio_left_in held high from edge 0 -> left_level=1 and left_press=1 for one cycle after edge 9; right outputs stay 0.
REQ-029 A bench SHALL cover: 5-cycle high glitch on gpio_right_in -> no change on right_level, right_press or right_release.
REQ-030 A bench SHALL cover: both inputs rising on the same edge, then falling 40 cycles later -> press pulses coincide, then release pulses coincide 40 cycles after the press pulses.
REQ-031 A bench SHALL cover: rst=0 for 3 cycles at count 6 of a left press -> no pulse; after release, left_press follows REQ-023 timing.
REQ-032 A bench SHALL cover, with GPIO_AUTO_REPEAT_EN: left held 40 cycles past its press pulse -> left_press pulses at +0, +20, +25, +30, +35, +40.
REQ-033 A bench SHALL cover, without GPIO_AUTO_REPEAT_EN: the same stimulus -> a single left_press pulse at +0 only.

Source files
------------

// File: rtl/gpio_input_conditioner.sv
// Two-channel button conditioner: 2-flop sync, debounce, press/release pulses; GPIO_AUTO_REPEAT_EN adds auto-repeat presses.
// Latency: level and pulse follow a held input by DEBOUNCE_CYCLES+1 edges; no backpressure, pulses are single-cycle.
module gpio_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int REPEAT_DELAY    = 26000000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_left_in,
  input  logic gpio_right_in,
  output logic left_level,
  output logic right_level,
  output logic left_press,
  output logic right_press,
  output logic left_release,
  output logic right_release
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is left, 1 is right.
  logic [1:0]    raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    level_q, level_d;
  logic [1:0]    press_q, press_d;
  logic [1:0]    release_q, release_d;
  logic [1:0]    rise;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  assign raw = {gpio_right_in, gpio_left_in};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    rise      = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

`ifdef GPIO_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY);
  // Reloading after each repeat keeps the counter bounded; needs REPEAT_PERIOD <= REPEAT_DELAY.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rpt_q [2];
  logic [RW-1:0] rpt_d [2];
  logic [1:0]    rpt_hit;

  always_comb begin
    rpt_hit = '0;
    for (int i = 0; i < 2; i++) begin
      rpt_d[i] = '0;
      if (level_q[i] && level_d[i]) begin
        if ((rpt_q[i] + 1'b1) == RPT_FIRE) begin
          rpt_hit[i] = 1'b1;
          rpt_d[i]   = RPT_RELOAD;
        end else begin
          rpt_d[i] = rpt_q[i] + 1'b1;
        end
      end
    end
    press_d = rise | rpt_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_q[0] <= '0;
      rpt_q[1] <= '0;
    end else begin
      rpt_q[0] <= rpt_d[0];
      rpt_q[1] <= rpt_d[1];
    end
  end
`else
  always_comb begin
    press_d = rise;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  assign left_level    = level_q[0];
  assign right_level   = level_q[1];
  assign left_press    = press_q[0];
  assign right_press   = press_q[1];
  assign left_release  = release_q[0];
  assign right_release = release_q[1];

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
module tb_gpio_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic gpio_left_in, gpio_right_in;
  logic left_level, right_level, left_press, right_press, left_release, right_release;

  int checks;
  int failures;

  logic        act;
  logic        mism;
  logic [63:0] pv;
  logic [63:0] exp_pv;

  gpio_input_conditioner #(
    .DEBOUNCE_CYCLES(8),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_left_in (gpio_left_in),
    .gpio_right_in(gpio_right_in),
    .left_level   (left_level),
    .right_level  (right_level),
    .left_press   (left_press),
    .right_press  (right_press),
    .left_release (left_release),
    .right_release(right_release)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {58'd0, left_level, right_level, left_press, right_press, left_release, right_release};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    gpio_left_in = 1'b0;
    gpio_right_in = 1'b0;
    tick(3);
    chkv("reset_outputs", all_outs(), 64'd0);
    rst = 1'b1;
    tick(2);

    // Left press: first sampled at edge 0, level/press visible after edge 9.
    gpio_left_in = 1'b1;
    tick(9);
    chk1("left_level_before_edge9", left_level, 1'b0);
    tick(1);
    chk1("left_level_edge9", left_level, 1'b1);
    chk1("left_press_edge9", left_press, 1'b1);
    chk1("right_level_idle", right_level, 1'b0);
    chk1("right_press_idle", right_press, 1'b0);
    tick(1);
    chk1("left_press_one_cycle", left_press, 1'b0);
    gpio_left_in = 1'b0;
    tick(9);
    chk1("left_level_before_fall", left_level, 1'b1);
    tick(1);
    chk1("left_level_fell", left_level, 1'b0);
    chk1("left_release_pulse", left_release, 1'b1);
    chk1("left_press_not_with_release", left_press, 1'b0);
    tick(1);
    chk1("left_release_one_cycle", left_release, 1'b0);

    // Right glitches of 5 and 7 synchronized cycles must be swallowed.
    act = 1'b0;
    gpio_right_in = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 5) gpio_right_in = 1'b0;
      tick(1);
      act = act | right_level | right_press | right_release;
    end
    chk1("glitch5_no_activity", act, 1'b0);
    act = 1'b0;
    gpio_right_in = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (k == 7) gpio_right_in = 1'b0;
      tick(1);
      act = act | right_level | right_press | right_release;
    end
    chk1("glitch7_no_activity", act, 1'b0);

    // Both channels rise together, fall 40 cycles later.
    gpio_left_in = 1'b1;
    gpio_right_in = 1'b1;
    tick(9);
    chkv("both_levels_before", {62'd0, left_level, right_level}, 64'd0);
    tick(1);
    chk1("both_left_press", left_press, 1'b1);
    chk1("both_right_press", right_press, 1'b1);
    mism = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      mism = mism | (left_press ^ right_press) | left_release | right_release;
    end
    gpio_left_in = 1'b0;
    gpio_right_in = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      mism = mism | (left_press ^ right_press) | left_release | right_release;
    end
    chkv("both_levels_held", {62'd0, left_level, right_level}, 64'd3);
    tick(1);
    chk1("both_left_release", left_release, 1'b1);
    chk1("both_right_release", right_release, 1'b1);
    chkv("both_no_press_at_release", {62'd0, left_press, right_press}, 64'd0);
    chk1("both_coincident_hold", mism, 1'b0);

    // Reset when the left debounce count has reached 6.
    tick(3);
    gpio_left_in = 1'b1;
    tick(8);
    rst = 1'b0;
    #1;
    chkv("midreset_async_clear", all_outs(), 64'd0);
    act = 1'b0;
    tick(3);
    act = act | left_level | left_press;
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      act = act | left_level | left_press | left_release;
    end
    chk1("midreset_no_early_pulse", act, 1'b0);
    tick(1);
    chk1("midreset_press_after_requal", left_press, 1'b1);
    chk1("midreset_level_after_requal", left_level, 1'b1);

    // Left held 40 cycles past its press pulse.
    pv = 64'd0;
    pv[0] = left_press;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      pv[k] = left_press;
    end
    exp_pv = 64'd1;
`ifdef GPIO_AUTO_REPEAT_EN
    exp_pv[20] = 1'b1;
    exp_pv[25] = 1'b1;
    exp_pv[30] = 1'b1;
    exp_pv[35] = 1'b1;
    exp_pv[40] = 1'b1;
`endif
    chkv("hold_press_pattern", pv, exp_pv);
    gpio_left_in = 1'b0;
    tick(10);
    chk1("hold_release_pulse", left_release, 1'b1);
    chk1("hold_level_low", left_level, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
